// File: rtl/csi2_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | csi2_pkg - shared CSI-2 data types and capture-state encoding.        |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package csi2_pkg;

  localparam logic [5:0] c_dt_fs      = 6'h00;
  localparam logic [5:0] c_dt_fe      = 6'h01;
  localparam logic [5:0] c_dt_ls      = 6'h02;
  localparam logic [5:0] c_dt_le      = 6'h03;
  localparam logic [5:0] c_dt_img_min = 6'h18;
  localparam logic [5:0] c_dt_img_max = 6'h2F;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_FS  = 2'd1,
    ST_IN_FRAME = 2'd2,
    ST_DROP     = 2'd3
  } capture_state_t;

  // Beats per line: ceil(word_count / 4), 15 bits covers the full 16-bit byte count.
  function automatic logic [14:0] beats_per_line(input logic [15:0] wc);
    logic [16:0] s;
    s = {1'b0, wc} + 17'd3;
    return s[16:2];
  endfunction

endpackage
`default_nettype wire

// File: rtl/csi2_bank_allocator.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | csi2_bank_allocator - ping-pong bank free/full tracking and choice.  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module csi2_bank_allocator (
  input  logic       clock_p_i,
  input  logic       reset_i,
  input  logic       claim_i,
  input  logic       complete_i,
  input  logic       complete_bank_i,
  input  logic [1:0] release_i,
  output logic       avail_o,
  output logic       pick_o
);

  logic [1:0] full_q, full_d;
  logic [1:0] writing_q, writing_d;
  logic       last_q, last_d;
  logic [1:0] w_rel;
  logic [1:0] w_free;
  logic       w_pref;

  // A release landing in the same cycle as an allocation is already usable.
  assign w_rel   = release_i & full_q & ~writing_q;
  assign w_free  = (~full_q & ~writing_q) | w_rel;
  assign w_pref  = ~last_q;
  assign avail_o = |w_free;
  assign pick_o  = w_free[w_pref] ? w_pref : last_q;

  always_comb begin
    full_d    = full_q & ~w_rel;
    writing_d = writing_q;
    last_d    = last_q;
    if (complete_i) begin
      writing_d[complete_bank_i] = 1'b0;
      full_d[complete_bank_i]    = 1'b1;
    end
    if (claim_i && avail_o) begin
      writing_d[pick_o] = 1'b1;
      last_d            = pick_o;
    end
  end

  always_ff @(posedge clock_p_i) begin
    if (reset_i) begin
      full_q    <= 2'b00;
      writing_q <= 2'b00;
      last_q    <= 1'b1;
    end else begin
      full_q    <= full_d;
      writing_q <= writing_d;
      last_q    <= last_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/csi2_capture_controller.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | csi2_capture_controller - CSI-2 frame capture into a two-bank buffer.|
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module csi2_capture_controller
  import csi2_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int LINE_WIDTH = 12
) (
  input  logic                  clock_p_i,
  input  logic                  reset_i,
  input  logic                  arm_i,
  input  logic                  continuous_i,
  input  logic [1:0]            vc_select_i,
  input  logic [5:0]            data_type_select_i,
  input  logic [LINE_WIDTH-1:0] expected_lines_i,
  input  logic                  interrupt_i,
  input  logic [1:0]            virtual_channel_i,
  input  logic [15:0]           word_count_i,
  input  logic [31:0]           image_data_i,
  input  logic [5:0]            image_data_type_i,
  input  logic                  image_data_enable_i,
  input  logic                  frame_start_i,
  input  logic                  frame_end_i,
  input  logic [1:0]            bank_release_i,
  output logic                  busy_o,
  output logic                  wr_enable_o,
  output logic                  wr_bank_o,
  output logic [ADDR_WIDTH-1:0] wr_addr_o,
  output logic [31:0]           wr_data_o,
  output logic                  frame_done_o,
  output logic                  done_bank_o,
  output logic [LINE_WIDTH-1:0] line_count_o,
  output logic                  err_short_line_o,
  output logic                  err_line_count_o,
  output logic                  err_overflow_o,
  output logic [7:0]            dropped_frames_o
);

  localparam logic [ADDR_WIDTH-1:0] c_addr_one = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [LINE_WIDTH-1:0] c_line_one = {{(LINE_WIDTH-1){1'b0}}, 1'b1};

  capture_state_t state_q, state_d;

  logic                  w_vc_ok, w_short_evt, w_fs_evt, w_fe_evt, w_beat;
  logic                  w_avail, w_pick;
  logic [14:0]           w_bpl;
  logic                  claim, start, restart, accept_beat, finish, drop, clr_err;

  logic                  cur_bank_q;
  logic [ADDR_WIDTH-1:0] ptr_q;
  logic                  wrapped_q;
  logic [14:0]           beat_cnt_q;
  logic [LINE_WIDTH-1:0] line_count_q;
  logic                  wr_enable_q, wr_bank_q;
  logic [ADDR_WIDTH-1:0] wr_addr_q;
  logic [31:0]           wr_data_q;
  logic                  frame_done_q, done_bank_q;
  logic                  err_short_q, err_lines_q, err_ovf_q;
  logic [7:0]            dropped_q;

  assign w_vc_ok     = (virtual_channel_i == vc_select_i);
  assign w_short_evt = interrupt_i & ~image_data_enable_i & w_vc_ok;
  assign w_fs_evt    = w_short_evt & frame_start_i;
  assign w_fe_evt    = w_short_evt & frame_end_i;
  assign w_beat      = image_data_enable_i & w_vc_ok & (image_data_type_i == data_type_select_i);
  assign w_bpl       = beats_per_line(word_count_i);

  csi2_bank_allocator u_alloc (
    .clock_p_i       (clock_p_i),
    .reset_i         (reset_i),
    .claim_i         (claim),
    .complete_i      (finish),
    .complete_bank_i (cur_bank_q),
    .release_i       (bank_release_i),
    .avail_o         (w_avail),
    .pick_o          (w_pick)
  );

  always_ff @(posedge clock_p_i) begin
    if (reset_i) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    claim       = 1'b0;
    start       = 1'b0;
    restart     = 1'b0;
    accept_beat = 1'b0;
    finish      = 1'b0;
    drop        = 1'b0;
    clr_err     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (arm_i) begin
          clr_err = 1'b1;
          state_d = ST_WAIT_FS;
        end
      end
      ST_WAIT_FS: begin
        if (w_fs_evt) begin
          if (w_avail) begin
            claim   = 1'b1;
            start   = 1'b1;
            state_d = ST_IN_FRAME;
          end else begin
            drop    = 1'b1;
            state_d = ST_DROP;
          end
        end
      end
      ST_IN_FRAME: begin
        if (w_fe_evt) begin
          finish  = 1'b1;
          state_d = continuous_i ? ST_WAIT_FS : ST_IDLE;
        end else if (w_fs_evt) begin
          restart = 1'b1;
        end else if (w_beat) begin
          accept_beat = 1'b1;
        end
      end
      ST_DROP: begin
        if (w_fe_evt) state_d = continuous_i ? ST_WAIT_FS : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock_p_i) begin
    if (reset_i) begin
      cur_bank_q   <= 1'b0;
      ptr_q        <= '0;
      wrapped_q    <= 1'b0;
      beat_cnt_q   <= '0;
      line_count_q <= '0;
      wr_enable_q  <= 1'b0;
      wr_bank_q    <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      frame_done_q <= 1'b0;
      done_bank_q  <= 1'b0;
      err_short_q  <= 1'b0;
      err_lines_q  <= 1'b0;
      err_ovf_q    <= 1'b0;
      dropped_q    <= '0;
    end else begin
      wr_enable_q  <= 1'b0;
      frame_done_q <= 1'b0;
      if (clr_err) begin
        err_short_q <= 1'b0;
        err_lines_q <= 1'b0;
        err_ovf_q   <= 1'b0;
      end
      if (start) cur_bank_q <= w_pick;
      if (start || restart) begin
        ptr_q        <= '0;
        wrapped_q    <= 1'b0;
        wr_addr_q    <= '0;
        beat_cnt_q   <= '0;
        line_count_q <= '0;
      end
      if (restart) err_lines_q <= 1'b1;
      if (accept_beat) begin
        // Once the last word has been written the pointer is frozen; further beats only flag overflow.
        if (wrapped_q) begin
          err_ovf_q <= 1'b1;
        end else begin
          wr_enable_q <= 1'b1;
          wr_bank_q   <= cur_bank_q;
          wr_addr_q   <= ptr_q;
          wr_data_q   <= image_data_i;
          ptr_q       <= ptr_q + c_addr_one;
          if (&ptr_q) wrapped_q <= 1'b1;
        end
        if (beat_cnt_q + 15'd1 == w_bpl) begin
          line_count_q <= line_count_q + c_line_one;
          beat_cnt_q   <= '0;
        end else begin
          beat_cnt_q <= beat_cnt_q + 15'd1;
        end
      end
      if (finish) begin
        if (beat_cnt_q != '0)                 err_short_q <= 1'b1;
        if (line_count_q != expected_lines_i) err_lines_q <= 1'b1;
        frame_done_q <= 1'b1;
        done_bank_q  <= cur_bank_q;
      end
      if (drop && dropped_q != 8'hFF) dropped_q <= dropped_q + 8'd1;
    end
  end

  assign busy_o           = (state_q != ST_IDLE);
  assign wr_enable_o      = wr_enable_q;
  assign wr_bank_o        = wr_bank_q;
  assign wr_addr_o        = wr_addr_q;
  assign wr_data_o        = wr_data_q;
  assign frame_done_o     = frame_done_q;
  assign done_bank_o      = done_bank_q;
  assign line_count_o     = line_count_q;
  assign err_short_line_o = err_short_q;
  assign err_line_count_o = err_lines_q;
  assign err_overflow_o   = err_ovf_q;
  assign dropped_frames_o = dropped_q;

endmodule
`default_nettype wire

// File: tb/tb_csi2_capture_controller.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_csi2_capture_controller - directed self-checking bench.           |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_csi2_capture_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        arm = 0, continuous = 0, interrupt = 0, ide = 0, fs = 0, fe = 0;
  logic [1:0]  vc_sel = 0, vc = 0, rel = 0;
  logic [5:0]  dt_sel = 6'h2A, dt = 0;
  logic [11:0] exp_lines = 12'd2;
  logic [15:0] wc = 0;
  logic [31:0] data = 0;

  logic        busy, wr_en, wr_bank, fdone, dbank, e_short, e_lines, e_ovf;
  logic [15:0] wr_addr;
  logic [31:0] wr_data;
  logic [11:0] lcount;
  logic [7:0]  dropped;
  logic        s_busy, s_wr_en, s_wr_bank, s_fdone, s_dbank, s_e_short, s_e_lines, s_e_ovf;
  logic [1:0]  s_wr_addr;
  logic [31:0] s_wr_data;
  logic [11:0] s_lcount;
  logic [7:0]  s_dropped;

  int n_checks = 0;
  int n_fail = 0;

  logic [15:0] wa[$];
  logic        wbk[$];
  logic [31:0] wd[$];
  logic [1:0]  sa[$];
  int          fd_cnt = 0;
  logic        fd_bank = 0;

  always #5 clk = ~clk;

  csi2_capture_controller #(.ADDR_WIDTH(16), .LINE_WIDTH(12)) dut (
    .clock_p_i(clk), .reset_i(reset), .arm_i(arm), .continuous_i(continuous),
    .vc_select_i(vc_sel), .data_type_select_i(dt_sel), .expected_lines_i(exp_lines),
    .interrupt_i(interrupt), .virtual_channel_i(vc), .word_count_i(wc), .image_data_i(data),
    .image_data_type_i(dt), .image_data_enable_i(ide), .frame_start_i(fs), .frame_end_i(fe),
    .bank_release_i(rel), .busy_o(busy), .wr_enable_o(wr_en), .wr_bank_o(wr_bank),
    .wr_addr_o(wr_addr), .wr_data_o(wr_data), .frame_done_o(fdone), .done_bank_o(dbank),
    .line_count_o(lcount), .err_short_line_o(e_short), .err_line_count_o(e_lines),
    .err_overflow_o(e_ovf), .dropped_frames_o(dropped));

  csi2_capture_controller #(.ADDR_WIDTH(2), .LINE_WIDTH(12)) dut_small (
    .clock_p_i(clk), .reset_i(reset), .arm_i(arm), .continuous_i(continuous),
    .vc_select_i(vc_sel), .data_type_select_i(dt_sel), .expected_lines_i(exp_lines),
    .interrupt_i(interrupt), .virtual_channel_i(vc), .word_count_i(wc), .image_data_i(data),
    .image_data_type_i(dt), .image_data_enable_i(ide), .frame_start_i(fs), .frame_end_i(fe),
    .bank_release_i(rel), .busy_o(s_busy), .wr_enable_o(s_wr_en), .wr_bank_o(s_wr_bank),
    .wr_addr_o(s_wr_addr), .wr_data_o(s_wr_data), .frame_done_o(s_fdone), .done_bank_o(s_dbank),
    .line_count_o(s_lcount), .err_short_line_o(s_e_short), .err_line_count_o(s_e_lines),
    .err_overflow_o(s_e_ovf), .dropped_frames_o(s_dropped));

  always @(negedge clk) begin
    if (wr_en) begin
      wa.push_back(wr_addr);
      wbk.push_back(wr_bank);
      wd.push_back(wr_data);
    end
    if (s_wr_en) sa.push_back(s_wr_addr);
    if (fdone) begin
      fd_cnt  = fd_cnt + 1;
      fd_bank = dbank;
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc(2);
    reset = 1'b0;
    wa.delete(); wbk.delete(); wd.delete(); sa.delete();
    fd_cnt = 0;
  endtask

  task automatic pulse_arm();
    arm = 1'b1;
    cyc();
    arm = 1'b0;
  endtask

  task automatic short_pkt(input logic [1:0] v, input logic s, input logic e);
    interrupt = 1'b1; vc = v; fs = s; fe = e;
    cyc();
    interrupt = 1'b0; fs = 1'b0; fe = 1'b0;
  endtask

  task automatic beat(input logic [1:0] v, input logic [5:0] t, input logic [15:0] w, input logic [31:0] d);
    ide = 1'b1; vc = v; dt = t; wc = w; data = d;
    cyc();
    ide = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cyc(2);
    n_checks++;
    if ({busy, wr_en, wr_bank, fdone, dbank, e_short, e_lines, e_ovf} !== 8'h00) begin
      n_fail++; $display("FAIL reset_flags got %b required 00000000", {busy, wr_en, wr_bank, fdone, dbank, e_short, e_lines, e_ovf});
    end
    n_checks++;
    if ({wr_addr, wr_data, lcount, dropped} !== 68'h0) begin
      n_fail++; $display("FAIL reset_values addr=%h data=%h lines=%h dropped=%h required all 0", wr_addr, wr_data, lcount, dropped);
    end
  endtask

  task automatic test_basic();
    do_reset();
    exp_lines = 12'd2;
    pulse_arm();
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy_after_arm got %b required 1", busy); end
    short_pkt(2'd0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) beat(2'd0, 6'h2A, 16'd8, 32'hA000_0000 + i);
    short_pkt(2'd0, 1'b0, 1'b1);
    cyc(3);
    n_checks++;
    if (wa.size() !== 4) begin
      n_fail++; $display("FAIL basic_write_count got %0d required 4", wa.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (wa[i] !== 16'(i) || wbk[i] !== 1'b0 || wd[i] !== 32'hA000_0000 + i) begin
          n_fail++; $display("FAIL basic_write%0d got addr=%h bank=%b data=%h required addr=%h bank=0 data=%h", i, wa[i], wbk[i], wd[i], i, 32'hA000_0000 + i);
        end
      end
    end
    n_checks++;
    if (fd_cnt !== 1 || fd_bank !== 1'b0) begin n_fail++; $display("FAIL basic_frame_done got cnt=%0d bank=%b required 1/0", fd_cnt, fd_bank); end
    n_checks++;
    if (lcount !== 12'd2 || {e_short, e_lines, e_ovf} !== 3'b000 || busy !== 1'b0) begin
      n_fail++; $display("FAIL basic_end lines=%0d errs=%b busy=%b required 2/000/0", lcount, {e_short, e_lines, e_ovf}, busy);
    end
  endtask

  task automatic test_continuous();
    do_reset();
    exp_lines = 12'd1;
    continuous = 1'b1;
    pulse_arm();
    for (int f = 0; f < 3; f++) begin
      short_pkt(2'd0, 1'b1, 1'b0);
      beat(2'd0, 6'h2A, 16'd4, 32'hB000_0000 + f);
      short_pkt(2'd0, 1'b0, 1'b1);
      cyc(2);
    end
    n_checks++;
    if (wa.size() !== 2 || wbk[0] !== 1'b0 || wbk[1] !== 1'b1) begin
      n_fail++; $display("FAIL cont_banks got writes=%0d banks=%b%b required 2 writes banks 0 then 1", wa.size(), wbk[0], wbk[1]);
    end
    n_checks++;
    if (dropped !== 8'd1 || fd_cnt !== 2 || busy !== 1'b1) begin
      n_fail++; $display("FAIL cont_drop got dropped=%0d done=%0d busy=%b required 1/2/1", dropped, fd_cnt, busy);
    end
    // Release of bank 0 lands in the same cycle as the frame start.
    rel = 2'b01;
    short_pkt(2'd0, 1'b1, 1'b0);
    rel = 2'b00;
    beat(2'd0, 6'h2A, 16'd4, 32'hB000_0010);
    continuous = 1'b0;
    short_pkt(2'd0, 1'b0, 1'b1);
    cyc(2);
    n_checks++;
    if (wa.size() !== 3 || wbk[2] !== 1'b0 || wd[2] !== 32'hB000_0010) begin
      n_fail++; $display("FAIL cont_release_same_cycle got writes=%0d bank=%b data=%h required 3/0/b0000010", wa.size(), wbk[2], wd[2]);
    end
    n_checks++;
    if (busy !== 1'b0 || fd_cnt !== 3 || fd_bank !== 1'b0 || dropped !== 8'd1) begin
      n_fail++; $display("FAIL cont_end got busy=%b done=%0d bank=%b dropped=%0d required 0/3/0/1", busy, fd_cnt, fd_bank, dropped);
    end
  endtask

  task automatic test_partial_line();
    do_reset();
    exp_lines = 12'd1;
    pulse_arm();
    short_pkt(2'd0, 1'b1, 1'b0);
    beat(2'd0, 6'h2A, 16'd6, 32'hC000_0000);
    n_checks++;
    if (lcount !== 12'd0) begin n_fail++; $display("FAIL partial_first_beat lines got %0d required 0", lcount); end
    beat(2'd0, 6'h2A, 16'd6, 32'hC000_0001);
    n_checks++;
    if (lcount !== 12'd1) begin n_fail++; $display("FAIL partial_second_beat lines got %0d required 1", lcount); end
    beat(2'd0, 6'h2A, 16'd6, 32'hC000_0002);
    short_pkt(2'd0, 1'b0, 1'b1);
    cyc(2);
    n_checks++;
    if ({e_short, e_lines, e_ovf} !== 3'b100 || wa.size() !== 3) begin
      n_fail++; $display("FAIL partial_short_err got errs=%b writes=%0d required 100/3", {e_short, e_lines, e_ovf}, wa.size());
    end
    pulse_arm();
    n_checks++;
    if (e_short !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL partial_arm_clear got err_short=%b busy=%b required 0/1", e_short, busy);
    end
  endtask

  task automatic test_vc_filter();
    do_reset();
    exp_lines = 12'd1;
    vc_sel = 2'd1;
    pulse_arm();
    short_pkt(2'd0, 1'b1, 1'b0);
    beat(2'd0, 6'h2A, 16'd4, 32'hD000_0000);
    short_pkt(2'd1, 1'b1, 1'b0);
    beat(2'd0, 6'h2A, 16'd4, 32'hD000_0001);
    beat(2'd1, 6'h2A, 16'd4, 32'hD000_0002);
    beat(2'd1, 6'h2B, 16'd4, 32'hD000_0003);
    short_pkt(2'd0, 1'b0, 1'b1);
    cyc(2);
    n_checks++;
    if (busy !== 1'b1 || fd_cnt !== 0) begin
      n_fail++; $display("FAIL vc_fe_ignored got busy=%b done=%0d required 1/0", busy, fd_cnt);
    end
    short_pkt(2'd1, 1'b0, 1'b1);
    cyc(2);
    n_checks++;
    if (wa.size() !== 1 || wd[0] !== 32'hD000_0002 || wa[0] !== 16'd0) begin
      n_fail++; $display("FAIL vc_writes got count=%0d data=%h addr=%h required 1/d0000002/0", wa.size(), wd[0], wa[0]);
    end
    n_checks++;
    if (fd_cnt !== 1 || lcount !== 12'd1 || {e_short, e_lines, e_ovf} !== 3'b000) begin
      n_fail++; $display("FAIL vc_end got done=%0d lines=%0d errs=%b required 1/1/000", fd_cnt, lcount, {e_short, e_lines, e_ovf});
    end
    vc_sel = 2'd0;
  endtask

  task automatic test_missing_fe();
    do_reset();
    exp_lines = 12'd1;
    pulse_arm();
    short_pkt(2'd0, 1'b1, 1'b0);
    beat(2'd0, 6'h2A, 16'd8, 32'hE000_0000);
    beat(2'd0, 6'h2A, 16'd8, 32'hE000_0001);
    short_pkt(2'd0, 1'b1, 1'b0);
    n_checks++;
    if (e_lines !== 1'b1 || lcount !== 12'd0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL missfe_restart got err_lines=%b lines=%0d busy=%b required 1/0/1", e_lines, lcount, busy);
    end
    beat(2'd0, 6'h2A, 16'd4, 32'hE000_0002);
    short_pkt(2'd0, 1'b0, 1'b1);
    cyc(2);
    n_checks++;
    if (wa.size() !== 3 || wa[2] !== 16'd0 || wbk[2] !== 1'b0 || wd[2] !== 32'hE000_0002) begin
      n_fail++; $display("FAIL missfe_second_frame got writes=%0d addr=%h bank=%b data=%h required 3/0/0/e0000002", wa.size(), wa[2], wbk[2], wd[2]);
    end
    n_checks++;
    if (fd_cnt !== 1 || fd_bank !== 1'b0 || e_lines !== 1'b1 || lcount !== 12'd1) begin
      n_fail++; $display("FAIL missfe_end got done=%0d bank=%b err_lines=%b lines=%0d required 1/0/1/1", fd_cnt, fd_bank, e_lines, lcount);
    end
  endtask

  task automatic test_overflow_and_reset();
    do_reset();
    exp_lines = 12'd1;
    pulse_arm();
    short_pkt(2'd0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) beat(2'd0, 6'h2A, 16'd20, 32'hF000_0000 + i);
    short_pkt(2'd0, 1'b0, 1'b1);
    cyc(2);
    n_checks++;
    if (sa.size() !== 4 || sa[0] !== 2'd0 || sa[3] !== 2'd3) begin
      n_fail++; $display("FAIL ovf_writes got count=%0d first=%0d last=%0d required 4/0/3", sa.size(), sa[0], sa[3]);
    end
    n_checks++;
    if (s_e_ovf !== 1'b1 || s_wr_addr !== 2'd3 || s_lcount !== 12'd1 || e_ovf !== 1'b0) begin
      n_fail++; $display("FAIL ovf_flags got small_ovf=%b small_addr=%0d small_lines=%0d wide_ovf=%b required 1/3/1/0", s_e_ovf, s_wr_addr, s_lcount, e_ovf);
    end
    pulse_arm();
    short_pkt(2'd0, 1'b1, 1'b0);
    ide = 1'b1; vc = 2'd0; dt = 6'h2A; wc = 16'd4; data = 32'h1234_5678;
    cyc();
    ide = 1'b0;
    n_checks++;
    if (wr_en !== 1'b1 || wr_bank !== 1'b1) begin
      n_fail++; $display("FAIL midframe_write got wr_en=%b bank=%b required 1/1", wr_en, wr_bank);
    end
    reset = 1'b1;
    cyc();
    n_checks++;
    if (busy !== 1'b0 || wr_en !== 1'b0 || wr_addr !== 16'd0 || s_e_ovf !== 1'b0 || s_busy !== 1'b0) begin
      n_fail++; $display("FAIL midframe_reset got busy=%b wr_en=%b addr=%h small_ovf=%b required 0/0/0/0", busy, wr_en, wr_addr, s_e_ovf);
    end
    reset = 1'b0;
    wa.delete(); wbk.delete(); wd.delete();
    pulse_arm();
    short_pkt(2'd0, 1'b1, 1'b0);
    beat(2'd0, 6'h2A, 16'd4, 32'h0BAD_F00D);
    cyc();
    n_checks++;
    if (wa.size() !== 1 || wbk[0] !== 1'b0 || dropped !== 8'd0) begin
      n_fail++; $display("FAIL reset_banks_free got writes=%0d bank=%b dropped=%0d required 1/0/0", wa.size(), wbk[0], dropped);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_continuous();
    test_partial_line();
    test_vc_filter();
    test_missing_fe();
    test_overflow_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
